// File: rtl/instr_encoder_loader.sv
// Encodes R/I/LW/SW instruction requests into RV32I words and writes them
// sequentially into a word-addressed instruction memory port.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cls,
    input  logic [2:0]        req_funct3,
    input  logic              req_funct7b5,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [11:0]       req_imm,
    input  logic              flush,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_FULL
    } state_e;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         wdata_d;
    logic [ADDR_W:0]     count_q;
    logic                accept;

    assign req_ready = !rst && !flush && (state_q != S_FULL);
    assign accept    = req_valid && req_ready;

    // NOTE: default assigned first so every path drives wdata_d and no latch is inferred.
    always_comb begin
        wdata_d = 32'd0;
        unique case (req_cls)
            2'b00:   wdata_d = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1,
                                req_funct3, req_rd, 7'b0110011};
            2'b01:   wdata_d = {req_imm, req_rs1, req_funct3, req_rd, 7'b0010011};
            2'b10:   wdata_d = {req_imm, req_rs1, 3'b010, req_rd, 7'b0000011};
            2'b11:   wdata_d = {req_imm[11:5], req_rs2, req_rs1, 3'b010,
                                req_imm[4:0], 7'b0100011};
            default: wdata_d = 32'd0;
        endcase
    end

    // NOTE: non-blocking assignments keep every register update in this block
    // order-independent, so all state advances together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            ptr_q   <= BASE;
            wdata_q <= 32'd0;
            count_q <= '0;
        end else if (flush) begin
            // Address and data registers keep their value; only the strobe is dropped.
            state_q <= S_EMPTY;
            we_q    <= 1'b0;
            ptr_q   <= BASE;
            count_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q  <= ptr_q;
                ptr_q   <= ptr_q + 1'b1;
                wdata_q <= wdata_d;
                count_q <= count_q + 1'b1;
                if ((count_q + 1'b1) == DEPTH_C) begin
                    state_q <= S_FULL;
                end else begin
                    state_q <= S_FILL;
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (state_q == S_FULL);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the loader.
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_cls;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [11:0]       req_imm;
    logic              flush;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;

    instr_encoder_loader #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cls     (req_cls),
        .req_funct3  (req_funct3),
        .req_funct7b5(req_funct7b5),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .flush       (flush),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .count       (count),
        .full        (full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: place each field at its bit offset by arithmetic.
    function automatic logic [31:0] model_enc(input int cls, input int f3, input int f7,
                                              input int rd, input int rs1, input int rs2,
                                              input int imm);
        int w;
        case (cls)
            0:       w = (f7 << 30) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
            1:       w = (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
            2:       w = (imm << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 'h03;
            default: w = ((imm / 32) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
                         + ((imm % 32) << 7) + 'h23;
        endcase
        return 32'(w);
    endfunction

    int          m_cnt;
    int          m_ptr;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_data;
    bit          m_after_rst;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt       = 0;
            m_ptr       = BASE_ADDR;
            m_we        = 1'b0;
            m_addr      = BASE_ADDR;
            m_data      = 32'd0;
            m_after_rst = 1'b1;
        end else begin
            m_after_rst = 1'b0;
            if (flush) begin
                m_cnt = 0;
                m_ptr = BASE_ADDR;
                m_we  = 1'b0;
            end else if (req_valid && m_cnt < DEPTH) begin
                m_we   = 1'b1;
                m_addr = m_ptr;
                m_data = model_enc(int'(req_cls), int'(req_funct3), int'(req_funct7b5),
                                   int'(req_rd), int'(req_rs1), int'(req_rs2), int'(req_imm));
                m_ptr  = (m_ptr + 1) % (1 << ADDR_W);
                m_cnt  = m_cnt + 1;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(!rst && !flush && m_cnt != DEPTH));
            check("imem_we", 32'(imem_we), 32'(m_we));
            check("count", 32'(count), 32'(m_cnt));
            check("full", 32'(full), 32'(m_cnt == DEPTH));
            if (m_we || m_after_rst) begin
                check("imem_addr", 32'(imem_addr), 32'(m_addr));
                check("imem_wdata", imem_wdata, m_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [11:0] imm);
        req_cls      = cls;
        req_funct3   = f3;
        req_funct7b5 = f7;
        req_rd       = rd;
        req_rs1      = rs1;
        req_rs2      = rs2;
        req_imm      = imm;
        req_valid    = 1'b1;
    endtask

    task automatic set_rand_req();
        set_req(2'($urandom), 3'($urandom), 1'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), 12'($urandom));
    endtask

    task automatic expect_write(input string name, input int addr, input logic [31:0] data);
        @(negedge clk);
        check({name, "_we"}, 32'(imem_we), 32'd1);
        check({name, "_addr"}, 32'(imem_addr), 32'(addr));
        check({name, "_data"}, imem_wdata, data);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        set_req(2'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        req_valid = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check("rst_data", imem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);

        // add x3,x1,x2
        set_req(2'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        step();
        req_valid = 1'b0;
        expect_write("add", 0, 32'h002081B3);
        check("add_count", 32'(count), 32'd1);

        flush = 1'b1;
        step();
        flush = 1'b0;

        // Back-to-back stream that also fills DEPTH=4
        set_req(2'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 12'd0);
        step();
        set_req(2'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 12'd10);
        expect_write("sub", 0, 32'h402081B3);
        step();
        set_req(2'd2, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, 12'd4);
        expect_write("addi", 1, 32'h00A00293);
        step();
        set_req(2'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd6, 12'd8);
        expect_write("lw", 2, 32'h00412303);
        step();
        set_req(2'd0, 3'd0, 1'b0, 5'd7, 5'd7, 5'd7, 12'd0);
        expect_write("sw", 3, 32'h00612423);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(req_ready), 32'd0);
        repeat (10) step();
        @(negedge clk);
        check("stall_count", 32'(count), 32'd4);
        check("stall_we", 32'(imem_we), 32'd0);

        // Ignored fields must not leak into the word
        flush = 1'b1;
        req_valid = 1'b0;
        step();
        flush = 1'b0;
        set_req(2'd2, 3'd7, 1'b1, 5'd6, 5'd2, 5'd31, 12'd4);
        step();
        set_req(2'd3, 3'd5, 1'b1, 5'd31, 5'd2, 5'd6, 12'd8);
        expect_write("lw_ign", 0, 32'h00412303);
        step();
        req_valid = 1'b0;
        expect_write("sw_ign", 1, 32'h00612423);

        // Flush coinciding with a valid request
        set_req(2'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_we", 32'(imem_we), 32'd0);
        check("flush_count", 32'(count), 32'd0);
        step();
        req_valid = 1'b0;
        expect_write("post_flush", BASE_ADDR, 32'h002081B3);

        // Reset in the middle of a stream
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rand_req();
            step();
        end
        set_req(2'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_data", imem_wdata, 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        step();
        req_valid = 1'b0;
        expect_write("post_rst", 0, 32'h002081B3);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 70) set_rand_req();
            else req_valid = 1'b0;
            flush = ($urandom_range(0, 99) < 6);
            rst   = ($urandom_range(0, 99) < 2);
            step();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        repeat (2) step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder counterpart to the core's main control decoder. Accepts instruction requests over a valid/ready handshake. Each request is an instruction class plus register, funct and immediate fields. The block assembles the RV32I 32-bit word for that class and writes it sequentially into instruction memory through a word-addressed write port. It is used by bench and boot logic to load programs limited to the classes the core decodes: R-type, I-type ALU, LW and SW.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, number of words loadable before full; must be ≤ 2^ADDR_W
BASE_ADDR, 0, word address of the first write after reset or flush

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_cls  input  2  00 R-type, 01 I-type ALU, 10 LW, 11 SW
req_funct3  input  3  funct3 for R/I classes (ignored for LW/SW)
req_funct7b5  input  1  instruction bit 30 for R-type (SUB/SRA); ignored otherwise
req_rd  input  5  destination register (ignored for SW)
req_rs1  input  5  source 1 / base register
req_rs2  input  5  source 2 (R-type) / store data register (SW); ignored otherwise
req_imm  input  12  immediate (I, LW, SW)
flush  input  1  restart loading at BASE_ADDR
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  word write address
imem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written since reset/flush
full  output  1  count == DEPTH

Behaviour:
- Reset (rst=1 at a clock edge): imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, state=EMPTY. req_ready=0 during the reset cycle.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. req_ready = !rst && !flush && state!=FULL (combinational). With valid held, one request is accepted per cycle.
- Latency: a request accepted at edge N produces imem_we=1 with its address and data during cycle N..N+1. Both are registered outputs; imem_we is a single-cycle pulse per accepted request.
- Address: the first write goes to BASE_ADDR; each later write goes to the previous address + 1, modulo 2^ADDR_W. count increments on each accepted request.
- Encoding, opcode in bits [6:0]:
  - R: {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 0110011}.
  - I: {imm[11:0], rs1, funct3, rd, 0010011}.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}; funct3 is forced to 010.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100023 as 7'b0100011}; funct3 is forced to 010.
  - Ignored fields never leak into the word.
- FSM:
  - EMPTY → FILL on the first acceptance.
  - FILL → FULL on the acceptance that makes count==DEPTH.
  - Any state → EMPTY on flush.
  - FULL holds while no flush; req_ready=0 and requests are not consumed.
  - full=1 only in FULL.
- Flush (sync, any cycle): at the next edge count=0, the address pointer returns to BASE_ADDR and state=EMPTY. A write registered in the same edge as flush is cancelled, so imem_we=0 in the following cycle. No request is accepted while flush=1.
- Reset mid-stream: same as flush plus imem_wdata=0. An in-flight write is dropped.
- Simultaneous rst and flush: rst wins; the result is identical.
- DEPTH boundary: the DEPTH-th request is accepted and written. The request after it stalls until flush.

Test Plan:
- After reset, valid R-type add (funct3=000, funct7b5=0, rd=3, rs1=1, rs2=2) → next cycle imem_we=1, imem_addr=0, imem_wdata=0x002081B3, count=1.
- Back-to-back sub x3,x1,x2; addi x5,x0,10; lw x6,4(x2); sw x6,8(x2) with valid held → writes at addresses 0..3 in consecutive cycles with data 0x402081B3, 0x00A00293, 0x00412303, 0x00612423.
- Ignored-field check: LW with funct3=111, rs2=31 → data still 0x00412303. SW with rd=31 → data still 0x00612423.
- Fill with DEPTH=4 → full=1 and req_ready=0 after 4 acceptances. A 5th request held valid for 10 cycles produces no write and count stays 4.
- Flush asserted in the same cycle as an acceptance → no imem_we pulse follows, count=0, and the next write goes to BASE_ADDR.
- rst asserted while valid is streaming → all outputs return to reset values at the next edge. Streaming resumes at address 0 after rst deasserts.
